// File: rtl/nios2_system_pio_pkg.sv
// Shared register map and bit positions for the transmit FIFO PIO.
package nios2_system_pio_pkg;

  typedef enum logic [1:0] {
    REG_DATA     = 2'd0,
    REG_STATUS   = 2'd1,
    REG_CONTROL  = 2'd2,
    REG_RESERVED = 2'd3
  } reg_addr_e;

  localparam int STATUS_EMPTY_BIT     = 0;
  localparam int STATUS_FULL_BIT      = 1;
  localparam int STATUS_OVERFLOW_BIT  = 2;
  localparam int STATUS_COUNT_LSB     = 8;
  localparam int STATUS_COUNT_MSB     = 15;

  localparam int CTRL_IRQ_EN_BIT      = 0;
  localparam int CTRL_FLUSH_BIT       = 1;
  localparam int CTRL_CLR_OVF_BIT     = 2;

  // Assemble the STATUS word; unused bits read as zero.
  function automatic logic [31:0] pack_status(input logic       empty,
                                              input logic       full,
                                              input logic       overflow,
                                              input logic [7:0] count);
    logic [31:0] word;
    word = '0;
    word[STATUS_EMPTY_BIT]                   = empty;
    word[STATUS_FULL_BIT]                    = full;
    word[STATUS_OVERFLOW_BIT]                = overflow;
    word[STATUS_COUNT_MSB:STATUS_COUNT_LSB]  = count;
    return word;
  endfunction

endpackage

// File: rtl/nios2_system_tx_fifo.sv
// Circular-buffer storage for the transmit path: push/pop/flush in,
// head word, occupancy and full/empty flags out.
module nios2_system_tx_fifo
  import nios2_system_pio_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 8,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Flush wins over everything; a push into a full FIFO is only taken when a pop frees a slot.
  always_comb begin
    do_pop   = pop && !empty && !flush;
    do_push  = push && !flush && (!full || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Storage array carries no reset; stale words are never visible once count is zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/nios2_system_transmit_fifo_pio.sv
// Avalon-MM slave feeding a transmit FIFO; exposes DATA, STATUS and CONTROL
// registers and streams the head word out with a valid/ready handshake.
module nios2_system_transmit_fifo_pio
  import nios2_system_pio_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  irq
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  wr_strobe;
  logic                  data_wr;
  logic                  ctrl_wr;
  logic                  flush;
  logic                  clr_ovf;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  overflow_q, overflow_d;
  logic                  irq_en_q, irq_en_d;
  logic                  unused_writedata;

  assign unused_writedata = &{1'b0, writedata};

  // Bus decode and next-state for the control/status flags; a fresh overflow beats a clear.
  always_comb begin
    wr_strobe  = chipselect && !write_n;
    data_wr    = wr_strobe && (reg_addr_e'(address) == REG_DATA);
    ctrl_wr    = wr_strobe && (reg_addr_e'(address) == REG_CONTROL);
    flush      = ctrl_wr && writedata[CTRL_FLUSH_BIT];
    clr_ovf    = ctrl_wr && writedata[CTRL_CLR_OVF_BIT];
    pop        = out_ready && !empty;
    irq_en_d   = irq_en_q;
    overflow_d = overflow_q;
    if (ctrl_wr) begin
      irq_en_d = writedata[CTRL_IRQ_EN_BIT];
    end
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (data_wr && full && !pop && !flush) begin
      overflow_d = 1'b1;
    end
  end

  nios2_system_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (data_wr),
    .push_data (writedata[DATA_WIDTH-1:0]),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Control/status flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
    end
  end

  // Zero-wait read mux; reading DATA peeks at the head without popping.
  always_comb begin
    readdata = '0;
    case (reg_addr_e'(address))
      REG_DATA: begin
        if (!empty) begin
          readdata = 32'(head);
        end
      end
      REG_STATUS:  readdata = pack_status(empty, full, overflow_q, 8'(count));
      REG_CONTROL: readdata[CTRL_IRQ_EN_BIT] = irq_en_q;
      default:     readdata = '0;
    endcase
  end

  assign out_valid = !empty;
  assign out_data  = head;
  assign irq       = irq_en_q && empty;

endmodule

// File: doc/nios2_system_transmit_fifo_pio.md
NIOS2_SYSTEM_TRANSMIT_FIFO_PIO -- requirements
Module: nios2_system_transmit_fifo_pio

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, width of each transmitted word (1..32).
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..128.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port address, input, 2, Avalon-MM word address.
REQ-006 SHALL have port chipselect, input, 1, slave select.
REQ-007 SHALL have port write_n, input, 1, active-low write strobe.
REQ-008 SHALL have port writedata, input, 32, write data.
REQ-009 SHALL have port readdata, output, 32, zero-wait read data.
REQ-010 SHALL have port out_data, output, DATA_WIDTH, head-of-FIFO word.
REQ-011 SHALL have port out_valid, output, 1, head word present.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the word.
REQ-013 SHALL have port irq, output, 1, level interrupt.

Function
REQ-014 SHALL decode a write as chipselect && !write_n; reads are combinational from address, with no wait states.
REQ-015 SHALL map address 0 to DATA; a write pushes writedata[DATA_WIDTH-1:0]; a read returns the zero-extended head word, or 0 when empty, and does not pop.
REQ-016 SHALL map address 1 to read-only STATUS: bit0 empty, bit1 full, bit2 overflow (sticky), bits[15:8] count, other bits 0.
REQ-017 SHALL map address 2 to CONTROL: bit0 irq_en (read/write); bit1 flush (write-1, self-clearing); bit2 clear-overflow (write-1); a read returns irq_en in bit0 and 0 elsewhere.
REQ-018 SHALL return 0 on reads of address 3 and ignore writes to it.
REQ-019 SHALL drive out_valid = !empty and out_data = head word, both from registered state.
REQ-020 SHALL pop one entry on each cycle in which out_valid && out_ready.
REQ-021 SHALL assert out_valid and update count on the clock edge that completes a push into an empty FIFO, i.e. 1-cycle latency.
REQ-022 SHALL accept a push when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle; count is unchanged on a simultaneous push and pop.
REQ-023 SHALL drop a push when full with no concurrent pop, leave FIFO contents unchanged, and set overflow.
REQ-024 SHALL give flush priority over push and pop in the same cycle: count becomes 0, the concurrent push is discarded, and overflow is not set.
REQ-025 SHALL give set priority over clear when clear-overflow and a new overflow event occur in the same cycle.
REQ-026 SHALL wrap the read and write pointers modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.
REQ-027 SHALL drive irq = irq_en && empty, combinationally from registers.

Reset
REQ-028 SHALL, on reset high at a clk edge, clear count, the pointers, overflow and irq_en, so that out_valid=0, irq=0 and STATUS=0x0000_0001.
REQ-029 SHALL discard FIFO contents on reset asserted mid-transfer, ignore any pending out_ready, and need no RAM clearing.

Structure
REQ-030 SHALL define the register address constants (DATA=0, STATUS=1, CONTROL=2) and the STATUS/CONTROL bit indices in shared package nios2_system_pio_pkg.
REQ-031 SHALL implement storage as one sub-module, nios2_system_tx_fifo, with push/pop/flush in and head/count/full/empty out; register decode stays in the top level.

Verification
REQ-032 SHALL cover: after reset, read STATUS -> 0x0000_0001; out_valid=0; irq=0.
REQ-033 SHALL cover: with out_ready=0, write 0x3FF to DATA -> next cycle out_valid=1, out_data=0x3FF, STATUS count=1; DATA read = 0x3FF.
REQ-034 SHALL cover: write 9 words 1..9 with DEPTH=8 and out_ready=0 -> full=1, overflow=1; drain with out_ready=1 -> words 1..8 in order, then empty.
REQ-035 SHALL cover: when full, push 0x55 in the same cycle as a pop -> count stays 8, overflow stays 0, and 0x55 emerges last.
REQ-036 SHALL cover: with 3 entries, write CONTROL=0x3 (flush + irq_en) while pushing -> count=0, out_valid=0, irq=1, overflow=0.
REQ-037 SHALL cover: assert reset with 5 entries and out_ready=1 -> next cycle STATUS=0x0000_0001, no further out_valid.
